// File: rtl/data_memory_if.sv
// CPU <-> data memory request/response bundle.
// The CPU drives requests on the master side and the memory responds on the slave side.
interface data_memory_if;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;
  logic       ERR;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT, ERR
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT, ERR
  );
endinterface

// File: rtl/data_memory.sv
// 256 x 8 data memory with a fixed multi-cycle access latency and a BUSYWAIT stall handshake.
//
// state | meaning
// IDLE  | waiting for exactly one of READ/WRITE; stall raised combinationally
// BUSY  | LATENCY cycles counting down on the latched request
// DONE  | stall released for one cycle; commit/readback already happened
module data_memory #(
  parameter int LATENCY   = 3,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  data_memory_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       op_wr_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [7:0] mem_q [256];
  logic       busywait_d;
  logic       last_busy;

  assign last_busy = (state_q == BUSY) && (cnt_q == 4'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.READ ^ bus.WRITE) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
            op_wr_q <= bus.WRITE;
            addr_q  <= bus.ADDRESS;
            wdata_q <= bus.WRITEDATA;
          end else if (bus.READ && bus.WRITE) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (!op_wr_q) rdata_q <= mem_q[addr_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is kept out of the FSM block so the reset-clear loop only exists when asked for.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      if (INIT_ZERO) begin
        for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
      end
    end else if (last_busy && op_wr_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Stall must rise in the same cycle the request appears, so this stays combinational.
  always_comb begin
    busywait_d = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE:    busywait_d = bus.READ ^ bus.WRITE;
        BUSY:    busywait_d = 1'b1;
        DONE:    busywait_d = 1'b0;
        default: busywait_d = 1'b0;
      endcase
    end
  end

  assign bus.BUSYWAIT = busywait_d;
  assign bus.READDATA = rdata_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: driver pushes expected READDATA per access, monitor pops on DONE.
// A second instance with INIT_ZERO=0 mirrors the same stimulus to observe storage surviving reset.
module tb_data_memory;
  localparam int LAT = 3;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  data_memory_if bus ();
  data_memory_if nz_bus ();

  data_memory #(.LATENCY(LAT), .INIT_ZERO(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );
  data_memory #(.LATENCY(LAT), .INIT_ZERO(1'b0)) dut_nz (
    .CLK(CLK), .RESET(RESET), .bus(nz_bus.slave)
  );

  assign nz_bus.READ      = bus.READ;
  assign nz_bus.WRITE     = bus.WRITE;
  assign nz_bus.ADDRESS   = bus.ADDRESS;
  assign nz_bus.WRITEDATA = bus.WRITEDATA;

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_rd;
  logic [7:0]  exp_q [$];
  int          run = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_rd = 8'h00;
  endtask

  // Monitor: samples mid-cycle; a low BUSYWAIT after a stall run marks a DONE cycle.
  always @(negedge CLK) begin
    #2;
    if (RESET) begin
      run = 0;
    end else if (bus.BUSYWAIT) begin
      run++;
    end else if (run > 0) begin
      check("stall_len", run, LAT + 1);
      if (exp_q.size() == 0) check("unexpected_done", exp_q.size(), 1);
      else check("readdata", bus.READDATA, exp_q.pop_front());
      run = 0;
    end
  end

  // One CPU access held until BUSYWAIT low is seen; reps>1 keeps the request up across DONE.
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input bit toggle, input int reps);
    int n;
    @(negedge CLK);
    bus.READ  = !wr;
    bus.WRITE = wr;
    for (int r = 0; r < reps; r++) begin
      if (r > 0) @(negedge CLK);
      bus.ADDRESS   = a;
      bus.WRITEDATA = d;
      if (wr) ref_mem[a] = d;
      else    ref_rd = ref_mem[a];
      exp_q.push_back(ref_rd);
      #2;
      n = 0;
      while (bus.BUSYWAIT && n < 40) begin
        @(negedge CLK);
        if (toggle) begin
          bus.ADDRESS   = 8'($urandom);
          bus.WRITEDATA = 8'($urandom);
        end
        #2;
        n++;
      end
      if (n >= 40) check("busy_timeout", n, 0);
    end
    @(negedge CLK);
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
  endtask

  initial begin
    bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = 8'h00; bus.WRITEDATA = 8'h00;
    model_reset();
    repeat (2) @(negedge CLK);
    #2;
    check("reset_busywait_while_rst", bus.BUSYWAIT, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #2;
    check("reset_readdata", bus.READDATA, 8'h00);
    check("reset_busywait", bus.BUSYWAIT, 0);
    check("reset_err", bus.ERR, 0);

    // Basic write/read, readdata hold across a later write, held read giving two accesses.
    access(1'b1, 8'h10, 8'hA5, 1'b0, 1);
    access(1'b0, 8'h10, 8'h00, 1'b0, 1);
    access(1'b1, 8'h11, 8'h5A, 1'b0, 1);
    check("hold_after_write", bus.READDATA, 8'hA5);
    access(1'b0, 8'h10, 8'h00, 1'b0, 2);

    // Address extremes with inputs scrambled during BUSY.
    access(1'b1, 8'hFF, 8'h3C, 1'b1, 1);
    access(1'b0, 8'hFF, 8'h00, 1'b1, 1);
    access(1'b1, 8'h00, 8'hC3, 1'b1, 1);
    access(1'b0, 8'h00, 8'h00, 1'b1, 1);
    check("read_ff_then_00", bus.READDATA, 8'hC3);

    // Protocol violation: both requests high in IDLE.
    @(negedge CLK);
    bus.READ = 1'b1; bus.WRITE = 1'b1; bus.ADDRESS = 8'h10; bus.WRITEDATA = 8'hEE;
    #2;
    check("err_busywait", bus.BUSYWAIT, 0);
    check("err_not_yet", bus.ERR, 0);
    @(negedge CLK);
    bus.READ = 1'b0; bus.WRITE = 1'b0;
    #2;
    check("err_pulse", bus.ERR, 1);
    check("err_readdata_kept", bus.READDATA, ref_rd);
    @(negedge CLK);
    #2;
    check("err_cleared", bus.ERR, 0);
    access(1'b0, 8'h10, 8'h00, 1'b0, 1);

    // Reset in the second BUSY cycle aborts the write.
    access(1'b1, 8'h20, 8'h55, 1'b0, 1);
    @(negedge CLK);
    bus.WRITE = 1'b1; bus.ADDRESS = 8'h20; bus.WRITEDATA = 8'h7E;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1; bus.WRITE = 1'b0;
    #2;
    check("abort_busywait_in_rst", bus.BUSYWAIT, 0);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    #2;
    check("abort_idle_busywait", bus.BUSYWAIT, 0);
    check("abort_readdata", bus.READDATA, 8'h00);
    access(1'b0, 8'h20, 8'h00, 1'b0, 1);
    check("nz_keeps_0x20", nz_bus.READDATA, 8'h55);

    // Request on the reset edge is discarded.
    @(negedge CLK);
    bus.READ = 1'b1; bus.ADDRESS = 8'h05; RESET = 1'b1;
    @(negedge CLK);
    bus.READ = 1'b0; RESET = 1'b0;
    model_reset();
    #2;
    check("req_on_reset_dropped", bus.BUSYWAIT, 0);
    @(negedge CLK);
    #2;
    check("req_on_reset_still_idle", bus.BUSYWAIT, 0);

    // Randomized traffic on a small address window to exercise read-after-write.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      access(1'($urandom), ra, 8'($urandom), 1'($urandom), 1);
    end

    repeat (3) @(negedge CLK);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
